sm83_bus_seq: RTL
=================

// Module: sm83_bus_seq
// PURPOSE
//  Self-timed memory-cycle sequencer for the SM83 core. It generates its own T-state phase,
//  runs read/write/idle M-cycles on the external bus and latches address and data.
//  Unlike the fixed four-T-state interface, it inserts wait states (TW) on ext_wait,
//  with a watchdog limit. While TW is active it stalls the core.
// PARAMETERS
//  ADR_WIDTH   16  address bus width
//  WORD_SIZE    8  data bus width
//  WAIT_LIMIT   8  max consecutive TW states per M-cycle (>=1); counter is $clog2(WAIT_LIMIT+1) bits
// PORTS
//  clk          in   1          single system clock, all state on posedge
//  n_reset      in   1          asynchronous, active-low reset
//  mread        in   1          request read cycle; sampled only in T4
//  mwrite       in   1          request write cycle; sampled only in T4
//  ain          in   ADR_WIDTH  address from core
//  aout         out  ADR_WIDTH  latched bus address
//  din          in   WORD_SIZE  data from core
//  dl_we        in   1          load din into data latch
//  ext_din      in   WORD_SIZE  data from external bus
//  ext_wait     in   1          external wait request
//  dout         out  WORD_SIZE  data latch
//  t1,t2,t3,t4  out  1 each     one-hot T-state phase (all 0 during TW)
//  tw           out  1          wait state active
//  stall        out  1          freeze core (== tw)
//  ext_data_oe  out  1          drive bus data
//  ext_data_lh  out  1          bus data latch-hold
//  p_rd, n_rd   out  1          read strobes
//  p_wr, n_wr   out  1          write strobes
//  bus_timeout  out  1          one-clock pulse: WAIT_LIMIT reached
//  req_conflict out  1          one-clock pulse: mread&&mwrite sampled in T4
// BEHAVIOUR
//  Reset (async, n_reset=0): phase=T1, cycle=IDLE, wait_cnt=0, aout=0, dout=0, pulses=0.
//   All control outputs go to IDLE values at once; this aborts any cycle in progress.
//  Phase FSM, one state per clk: T1->T2->T3->T4->T1.
//   In T2: if cycle!=IDLE and ext_wait=1, the next state is TW, else T3.
//   In TW: wait_cnt increments each clk.
//   TW->T3 when ext_wait=0, or when wait_cnt reaches WAIT_LIMIT.
//   On the limit exit, bus_timeout pulses for 1 clk, coincident with entering T3.
//   wait_cnt clears in T3.
//   ext_wait is ignored in IDLE cycles and outside T2/TW.
//  Cycle type is latched on the T4->T1 edge:
//   mread -> RD, else mwrite -> WR, else IDLE.
//   mread&&mwrite -> RD; req_conflict pulses 1 clk.
//   aout <= ain on the same edge, only when RD or WR is latched; otherwise aout holds.
//  Control outputs are combinational from the registered phase and cycle.
//   IDLE: oe=0, lh=0, p_rd=1, n_rd=1, p_wr=0, n_wr=0.
//   RD:   as IDLE, but lh=t3.
//   WR:   oe=p_wr=(t2|tw|t3); n_wr=t3; n_rd=0; p_rd=t4.
//  Data latch:
//   Capture is on the T3->T4 edge of an RD cycle: dout <= ext_din.
//   Otherwise, when dl_we=1, dout <= din.
//   Capture has priority over dl_we on the same edge; in that case dl_we is dropped.
//  Latency: read data is valid in dout from T4 of the same M-cycle.
//   Each TW adds exactly 1 clk.
// TESTING
//  1. Reset, mread=1, ain=16'hC000 in T4, ext_din=8'h5A
//     -> aout=C000 from T1; lh=1 only in T3; dout=5A at T4; no TW.
//  2. Reset, mwrite=1, din=8'h3C with dl_we, ain=16'hFF80
//     -> oe/p_wr high in T2..T3; n_wr only in T3; n_rd=0 all cycle; p_rd=1 in T4 only.
//  3. RD cycle, ext_wait=1 for 2 clks from T2
//     -> T1,T2,TW,TW,T3,T4; stall=1 for 2 clks; dout captured after the final T3.
//  4. WAIT_LIMIT=3, ext_wait held 1 in WR cycle
//     -> exactly 3 TW, bus_timeout pulses on T3 entry, cycle completes, next cycle normal.
//  5. n_reset=0 mid-WR in T3 -> oe=0, p_wr=0, n_wr=0 at once;
//     after release, phase=T1, IDLE, aout=0, dout=0.
//  6. mread=mwrite=1 in T4 -> RD cycle runs, req_conflict=1 for 1 clk, no write strobes;
//     dl_we=1 on the capture edge -> dout=ext_din.

Source files
------------

// File: rtl/sm83_bus_seq_if.sv
// sm83_bus_seq_if: bundle of core-side request/data signals and external bus
// strobes for the SM83 memory-cycle sequencer.
//
//   master modport : the sequencer (drives aout, dout, phase, strobes, pulses)
//   slave modport  : core/bus side (drives mread, mwrite, ain, din, dl_we,
//                    ext_din, ext_wait)
//
// Signals:
//   mread, mwrite   cycle requests, sampled in T4
//   ain / aout      core address / latched bus address
//   din / dout      core data / data latch
//   dl_we           load din into the data latch
//   ext_din         data from the external bus
//   ext_wait        external wait request
//   t1..t4, tw      phase flags (one-hot, all T flags low during TW)
//   stall           freeze core while in TW
//   ext_data_oe     drive bus data
//   ext_data_lh     bus data latch-hold
//   p_rd, n_rd      read strobes
//   p_wr, n_wr      write strobes
//   bus_timeout     one-clock pulse when the wait limit forced T3
//   req_conflict    one-clock pulse when mread and mwrite were both seen in T4
interface sm83_bus_seq_if #(
    parameter int unsigned ADR_WIDTH = 16,
    parameter int unsigned WORD_SIZE = 8
);
    logic                 mread;
    logic                 mwrite;
    logic [ADR_WIDTH-1:0] ain;
    logic [ADR_WIDTH-1:0] aout;
    logic [WORD_SIZE-1:0] din;
    logic                 dl_we;
    logic [WORD_SIZE-1:0] ext_din;
    logic                 ext_wait;
    logic [WORD_SIZE-1:0] dout;
    logic                 t1;
    logic                 t2;
    logic                 t3;
    logic                 t4;
    logic                 tw;
    logic                 stall;
    logic                 ext_data_oe;
    logic                 ext_data_lh;
    logic                 p_rd;
    logic                 n_rd;
    logic                 p_wr;
    logic                 n_wr;
    logic                 bus_timeout;
    logic                 req_conflict;

    modport master (
        input  mread, mwrite, ain, din, dl_we, ext_din, ext_wait,
        output aout, dout, t1, t2, t3, t4, tw, stall, ext_data_oe, ext_data_lh,
        output p_rd, n_rd, p_wr, n_wr, bus_timeout, req_conflict
    );

    modport slave (
        output mread, mwrite, ain, din, dl_we, ext_din, ext_wait,
        input  aout, dout, t1, t2, t3, t4, tw, stall, ext_data_oe, ext_data_lh,
        input  p_rd, n_rd, p_wr, n_wr, bus_timeout, req_conflict
    );
endinterface

// File: rtl/sm83_bus_seq.sv
// sm83_bus_seq: self-timed M-cycle sequencer for the SM83 core.
//
// Generates its own T-state phase (T1..T4 plus wait states TW), runs read,
// write or idle M-cycles on the external bus, and latches address and data.
// A cycle stretched by ext_wait is capped at WAIT_LIMIT wait states; hitting
// the cap forces T3 and pulses bus_timeout.
//
// Ports:
//   clk      system clock, all state on posedge
//   n_reset  asynchronous active-low reset (aborts any cycle in progress)
//   bus      sm83_bus_seq_if.master: requests, data, phase flags, strobes
//
// Parameters:
//   ADR_WIDTH   address bus width
//   WORD_SIZE   data bus width
//   WAIT_LIMIT  max consecutive TW states per M-cycle (>= 1)
module sm83_bus_seq #(
    parameter int unsigned ADR_WIDTH  = 16,
    parameter int unsigned WORD_SIZE  = 8,
    parameter int unsigned WAIT_LIMIT = 8
) (
    input  logic           clk,
    input  logic           n_reset,
    sm83_bus_seq_if.master bus
);

    localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        PhT1,
        PhT2,
        PhT3,
        PhT4,
        PhTw
    } phase_e;

    typedef enum logic [1:0] {
        CycIdle,
        CycRd,
        CycWr
    } cycle_e;

    phase_e               phase_q, phase_d;
    cycle_e               cycle_q, cycle_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]     wait_cnt_inc;
    logic [ADR_WIDTH-1:0] aout_q, aout_d;
    logic [WORD_SIZE-1:0] dout_q, dout_d;
    logic                 bus_timeout_q, bus_timeout_d;
    logic                 req_conflict_q, req_conflict_d;

    // Next-state: phase sequencing, wait counting, cycle/address latch, data latch.
    always_comb begin
        phase_d        = phase_q;
        cycle_d        = cycle_q;
        wait_cnt_d     = wait_cnt_q;
        aout_d         = aout_q;
        dout_d         = dout_q;
        bus_timeout_d  = 1'b0;
        req_conflict_d = 1'b0;
        wait_cnt_inc   = wait_cnt_q + CNT_ONE;

        // Core load is the low-priority source; a read capture below overrides it.
        if (bus.dl_we) begin
            dout_d = bus.din;
        end

        unique case (phase_q)
            PhT1: begin
                phase_d = PhT2;
            end
            PhT2: begin
                // Idle cycles never wait.
                if (cycle_q != CycIdle && bus.ext_wait) begin
                    phase_d = PhTw;
                end else begin
                    phase_d = PhT3;
                end
            end
            PhTw: begin
                wait_cnt_d = wait_cnt_inc;
                if (!bus.ext_wait) begin
                    phase_d = PhT3;
                end else if (wait_cnt_inc == CNT_LIMIT) begin
                    // Wait still asserted after the last allowed TW: force completion.
                    phase_d       = PhT3;
                    bus_timeout_d = 1'b1;
                end
            end
            PhT3: begin
                phase_d    = PhT4;
                wait_cnt_d = '0;
                if (cycle_q == CycRd) begin
                    dout_d = bus.ext_din;
                end
            end
            PhT4: begin
                phase_d        = PhT1;
                req_conflict_d = bus.mread & bus.mwrite;
                // Read wins a conflicting request; aout only moves on a real bus cycle.
                if (bus.mread) begin
                    cycle_d = CycRd;
                    aout_d  = bus.ain;
                end else if (bus.mwrite) begin
                    cycle_d = CycWr;
                    aout_d  = bus.ain;
                end else begin
                    cycle_d = CycIdle;
                end
            end
            default: begin
                phase_d = PhT1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            phase_q        <= PhT1;
            cycle_q        <= CycIdle;
            wait_cnt_q     <= '0;
            aout_q         <= '0;
            dout_q         <= '0;
            bus_timeout_q  <= 1'b0;
            req_conflict_q <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            cycle_q        <= cycle_d;
            wait_cnt_q     <= wait_cnt_d;
            aout_q         <= aout_d;
            dout_q         <= dout_d;
            bus_timeout_q  <= bus_timeout_d;
            req_conflict_q <= req_conflict_d;
        end
    end

    // Control outputs decode only registered state, so reset forces idle values at once.
    logic ph_t1, ph_t2, ph_t3, ph_t4, ph_tw;
    logic is_rd, is_wr;
    logic wr_drive;

    always_comb begin
        ph_t1    = (phase_q == PhT1);
        ph_t2    = (phase_q == PhT2);
        ph_t3    = (phase_q == PhT3);
        ph_t4    = (phase_q == PhT4);
        ph_tw    = (phase_q == PhTw);
        is_rd    = (cycle_q == CycRd);
        is_wr    = (cycle_q == CycWr);
        // Write data is driven from T2 through T3, including any wait states.
        wr_drive = is_wr & (ph_t2 | ph_tw | ph_t3);
    end

    assign bus.t1           = ph_t1;
    assign bus.t2           = ph_t2;
    assign bus.t3           = ph_t3;
    assign bus.t4           = ph_t4;
    assign bus.tw           = ph_tw;
    assign bus.stall        = ph_tw;
    assign bus.ext_data_oe  = wr_drive;
    assign bus.ext_data_lh  = is_rd & ph_t3;
    assign bus.p_rd         = is_wr ? ph_t4 : 1'b1;
    assign bus.n_rd         = ~is_wr;
    assign bus.p_wr         = wr_drive;
    assign bus.n_wr         = is_wr & ph_t3;
    assign bus.aout         = aout_q;
    assign bus.dout         = dout_q;
    assign bus.bus_timeout  = bus_timeout_q;
    assign bus.req_conflict = req_conflict_q;

    // Structural sanity: exactly one phase flag and a bounded wait counter.
    a_phase_onehot: assert property (@(posedge clk) disable iff (!n_reset)
        $onehot({ph_t1, ph_t2, ph_t3, ph_t4, ph_tw}));
    a_wait_bounded: assert property (@(posedge clk) disable iff (!n_reset)
        wait_cnt_q <= CNT_LIMIT);
    a_idle_no_wait: assert property (@(posedge clk) disable iff (!n_reset)
        ph_tw |-> (cycle_q != CycIdle));

endmodule
